mips_multicycle_ctrl: RTL and testbench
=======================================

Name: mips_multicycle_ctrl

Overview:
Multicycle MIPS main controller FSM: the producer side of the 3-bit ALUOp code that the ALU decoder consumes. Sequences each instruction through fetch/decode/execute/memory/writeback states and drives datapath mux selects, write strobes and ALUOp. Sits in the control unit beside the ALU decoder, fed by the instruction-register opcode and the ALU zero flag.

Parameters:
- MEM_WAIT_EN_DEFAULT, 1, 1 = honour mem_ready; 0 = treat mem_ready as constantly 1

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- op  in  6  opcode from instruction register (stable after FETCH)
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access complete this cycle
- IorD  out  1  0 = PC address, 1 = ALUOut address
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  instruction register load
- RegDst  out  1  0 = rt, 1 = rd
- MemtoReg  out  1  0 = ALUOut, 1 = memory data
- RegWrite  out  1  register file write
- ALUSrcA  out  1  0 = PC, 1 = reg A
- ALUSrcB  out  2  00 = B, 01 = 4, 10 = imm, 11 = imm<<2
- ExtZero  out  1  1 = zero-extend imm (ori/xori)
- ALUOp  out  3  000 add, 001 beq-sub, 010 funct, 011 slti, 100 bne-sub, 110 ori, 111 xori
- PCSrc  out  2  00 = ALUResult, 01 = ALUOut, 10 = jump target
- PCEn  out  1  PC load = PCWrite | (beq & zero) | (bne & ~zero)
- illegal_op  out  1  one-cycle pulse in DECODE on an unsupported opcode

Behaviour:
- Reset (async, reset_n = 0): state = FETCH. All strobes (MemWrite, IRWrite, RegWrite, PCEn) forced to 0 while reset_n is low. Mid-instruction reset abandons the instruction with no write.
- Outputs are combinational from the registered state, plus op in IEXEC/BRANCH and mem_ready in FETCH/MEMRD/MEMWR. Any output not listed for a state is 0.
- FETCH: ALUSrcB = 01, ALUOp = 000. IRWrite = PCEn = mem_ready. Hold until mem_ready, then go to DECODE.
- DECODE: ALUSrcB = 11, ALUOp = 000 (branch target into ALUOut). Next state by op:
  - 100011 lw / 101011 sw → MEMADR
  - 000000 R-type → EXECUTE
  - 000100 beq / 000101 bne → BRANCH
  - 001000 addi / 001010 slti / 001101 ori / 001110 xori → IEXEC
  - 000010 j → JUMP
  - any other op → FETCH, with illegal_op = 1
- MEMADR: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 000. Next: MEMRD for lw, MEMWR for sw.
- MEMRD: IorD = 1. Hold until mem_ready, then go to MEMWB.
- MEMWB: MemtoReg = 1, RegWrite = 1, RegDst = 0. Next: FETCH.
- MEMWR: IorD = 1. MemWrite is held high until the mem_ready cycle, then go to FETCH.
- EXECUTE: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 010. Next: ALUWB.
- ALUWB: RegDst = 1, RegWrite = 1. Next: FETCH.
- BRANCH: ALUSrcA = 1, ALUSrcB = 00, PCSrc = 01.
  - beq: ALUOp = 001, PCEn = zero.
  - bne: ALUOp = 100, PCEn = ~zero.
  - Next: FETCH.
- IEXEC: ALUSrcA = 1, ALUSrcB = 10.
  - ALUOp = 000 for addi, 011 for slti, 110 for ori, 111 for xori.
  - ExtZero = 1 for ori/xori only.
  - Next: IWB.
- IWB: RegDst = 0, RegWrite = 1. Next: FETCH.
- JUMP: PCSrc = 10, PCEn = 1. Next: FETCH.
- Latency with mem_ready tied to 1 (cycles, FETCH to the next FETCH): R-type 4, lw 5, sw 4, beq/bne 3, I-type ALU 4, j 3. Each mem_ready low cycle adds one cycle.
- Unreachable state encodings recover to FETCH on the next edge, with no strobes asserted.

Optional Feature:
- CTRL_RETIRE_CNT_EN.
- Defined: adds output retired[31:0]. Reset value 0. Increments by 1 on every transition into FETCH from a terminal state (MEMWB, MEMWR, ALUWB, IWB, BRANCH, JUMP); illegal ops are not counted. Wraps 0xFFFFFFFF → 0.
- Undefined: no port, no counter logic.

Decomposition:
- Package mips_ctrl_pkg holds:
  - state_t enum (4-bit, 12 states)
  - opcode localparams (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI, OP_ORI, OP_XORI, OP_J)
  - ALUOp localparams (ALUOP_ADD, ALUOP_BEQ, ALUOP_FUNCT, ALUOP_SLTI, ALUOP_BNE, ALUOP_ORI, ALUOP_XORI)
  - ALUSrcB and PCSrc select constants
- One natural sub-module: mips_ctrl_outdec, the combinational state/op → control-vector decoder. The FSM register and next-state logic stay in the top module.

Test Plan:
- Reset: reset_n = 0 mid-MEMWR with MemWrite high → MemWrite drops to 0 asynchronously; state is FETCH after release.
- lw (op = 100011), mem_ready = 1:
  - states FETCH→DECODE→MEMADR→MEMRD→MEMWB over 5 cycles
  - RegWrite = 1 and MemtoReg = 1 only in cycle 5
- sw with mem_ready low for 3 cycles in MEMWR → MemWrite high for 4 cycles, then FETCH; RegWrite never asserted.
- beq with zero = 1 → BRANCH drives ALUOp = 001, PCEn = 1. bne with zero = 1 → ALUOp = 100, PCEn = 0.
- ori (001101) → IEXEC drives ALUOp = 110, ExtZero = 1, ALUSrcB = 10; the next cycle (IWB) drives RegWrite = 1, RegDst = 0.
- op = 111111 → illegal_op pulses for 1 cycle in DECODE, next state FETCH, no strobes. With CTRL_RETIRE_CNT_EN, retired is unchanged.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS main controller.
package mips_ctrl_pkg;

   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEMADR  = 4'd2,
      MEMRD   = 4'd3,
      MEMWB   = 4'd4,
      MEMWR   = 4'd5,
      EXECUTE = 4'd6,
      ALUWB   = 4'd7,
      BRANCH  = 4'd8,
      IEXEC   = 4'd9,
      IWB     = 4'd10,
      JUMP    = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [2:0] ALUOP_ADD   = 3'b000;
   localparam logic [2:0] ALUOP_BEQ   = 3'b001;
   localparam logic [2:0] ALUOP_FUNCT = 3'b010;
   localparam logic [2:0] ALUOP_SLTI  = 3'b011;
   localparam logic [2:0] ALUOP_BNE   = 3'b100;
   localparam logic [2:0] ALUOP_ORI   = 3'b110;
   localparam logic [2:0] ALUOP_XORI  = 3'b111;

   localparam logic [1:0] SRCB_REG   = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_IMMSH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef struct packed {
      logic       iord;
      logic       mem_write;
      logic       ir_write;
      logic       reg_dst;
      logic       memto_reg;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic       ext_zero;
      logic [2:0] alu_op;
      logic [1:0] pc_src;
      logic       pc_en;
      logic       illegal_op;
   } ctrl_t;

   function automatic logic is_legal_op(input logic [5:0] op);
      case (op)
         OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE,
         OP_ADDI, OP_SLTI, OP_ORI, OP_XORI, OP_J: return 1'b1;
         default:                                 return 1'b0;
      endcase
   endfunction

   function automatic logic is_terminal(input state_t s);
      case (s)
         MEMWB, MEMWR, ALUWB, IWB, BRANCH, JUMP: return 1'b1;
         default:                                return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Combinational decoder from controller state (plus op/zero/mem_ready) to the control vector.
module mips_ctrl_outdec
   import mips_ctrl_pkg::*;
(
   input  state_t      state,
   input  logic [5:0]  op,
   input  logic        zero,
   input  logic        mem_rdy,
   output ctrl_t       ctrl
);

   always_comb begin
      ctrl = '0;
      case (state)
         FETCH: begin
            ctrl.alu_src_b = SRCB_FOUR;
            ctrl.ir_write  = mem_rdy;
            ctrl.pc_en     = mem_rdy;
         end
         DECODE: begin
            ctrl.alu_src_b  = SRCB_IMMSH;
            ctrl.illegal_op = ~is_legal_op(op);
         end
         MEMADR: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
         end
         MEMRD: ctrl.iord = 1'b1;
         MEMWB: begin
            ctrl.memto_reg = 1'b1;
            ctrl.reg_write = 1'b1;
         end
         MEMWR: begin
            ctrl.iord      = 1'b1;
            ctrl.mem_write = 1'b1;
         end
         EXECUTE: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_REG;
            ctrl.alu_op    = ALUOP_FUNCT;
         end
         ALUWB: begin
            ctrl.reg_dst   = 1'b1;
            ctrl.reg_write = 1'b1;
         end
         BRANCH: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_REG;
            ctrl.pc_src    = PCSRC_ALUOUT;
            if (op == OP_BNE) begin
               ctrl.alu_op = ALUOP_BNE;
               ctrl.pc_en  = ~zero;
            end else begin
               ctrl.alu_op = ALUOP_BEQ;
               ctrl.pc_en  = zero;
            end
         end
         IEXEC: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
            case (op)
               OP_SLTI: ctrl.alu_op = ALUOP_SLTI;
               OP_ORI: begin
                  ctrl.alu_op   = ALUOP_ORI;
                  ctrl.ext_zero = 1'b1;
               end
               OP_XORI: begin
                  ctrl.alu_op   = ALUOP_XORI;
                  ctrl.ext_zero = 1'b1;
               end
               default: ctrl.alu_op = ALUOP_ADD;
            endcase
         end
         IWB: ctrl.reg_write = 1'b1;
         JUMP: begin
            ctrl.pc_src = PCSRC_JUMP;
            ctrl.pc_en  = 1'b1;
         end
         default: ctrl = '0;
      endcase
   end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS main controller FSM: state register, next-state logic, strobe gating.
// Optional CTRL_RETIRE_CNT_EN adds a 32-bit retired-instruction counter output.
module mips_multicycle_ctrl
   import mips_ctrl_pkg::*;
#(
   parameter bit MEM_WAIT_EN_DEFAULT = 1'b1
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [5:0] op,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       IorD,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegDst,
   output logic       MemtoReg,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic       ExtZero,
   output logic [2:0] ALUOp,
   output logic [1:0] PCSrc,
   output logic       PCEn,
   output logic       illegal_op
`ifdef CTRL_RETIRE_CNT_EN
   ,
   output logic [31:0] retired
`endif
);

   state_t state;
   state_t state_next;
   ctrl_t  ctrl;
   logic   mem_rdy;

   assign mem_rdy = MEM_WAIT_EN_DEFAULT ? mem_ready : 1'b1;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= FETCH;
      else          state <= state_next;
   end

   always_comb begin
      state_next = FETCH;
      case (state)
         FETCH:  state_next = mem_rdy ? DECODE : FETCH;
         DECODE: begin
            case (op)
               OP_LW, OP_SW:                       state_next = MEMADR;
               OP_RTYPE:                           state_next = EXECUTE;
               OP_BEQ, OP_BNE:                     state_next = BRANCH;
               OP_ADDI, OP_SLTI, OP_ORI, OP_XORI:  state_next = IEXEC;
               OP_J:                               state_next = JUMP;
               default:                            state_next = FETCH;
            endcase
         end
         MEMADR:  state_next = (op == OP_SW) ? MEMWR : MEMRD;
         MEMRD:   state_next = mem_rdy ? MEMWB : MEMRD;
         MEMWR:   state_next = mem_rdy ? FETCH : MEMWR;
         EXECUTE: state_next = ALUWB;
         IEXEC:   state_next = IWB;
         default: state_next = FETCH;
      endcase
   end

   mips_ctrl_outdec u_outdec (
      .state   (state),
      .op      (op),
      .zero    (zero),
      .mem_rdy (mem_rdy),
      .ctrl    (ctrl)
   );

   // Strobes are gated by reset_n so a reset mid-access drops them without waiting for a clock.
   assign MemWrite   = ctrl.mem_write & reset_n;
   assign IRWrite    = ctrl.ir_write  & reset_n;
   assign RegWrite   = ctrl.reg_write & reset_n;
   assign PCEn       = ctrl.pc_en     & reset_n;
   assign IorD       = ctrl.iord;
   assign RegDst     = ctrl.reg_dst;
   assign MemtoReg   = ctrl.memto_reg;
   assign ALUSrcA    = ctrl.alu_src_a;
   assign ALUSrcB    = ctrl.alu_src_b;
   assign ExtZero    = ctrl.ext_zero;
   assign ALUOp      = ctrl.alu_op;
   assign PCSrc      = ctrl.pc_src;
   assign illegal_op = ctrl.illegal_op;

`ifdef CTRL_RETIRE_CNT_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         retired <= '0;
      else if (state_next == FETCH && is_terminal(state))
         retired <= retired + 32'd1;
   end
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: per-instruction expected control trace plus pinned literals.
module tb_mips_multicycle_ctrl;

   typedef struct packed {
      logic       iord;
      logic       memw;
      logic       irw;
      logic       regdst;
      logic       mtr;
      logic       regw;
      logic       srca;
      logic [1:0] srcb;
      logic       ext;
      logic [2:0] aluop;
      logic [1:0] pcsrc;
      logic       pcen;
      logic       ill;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [5:0] op;
   logic       zero;
   logic       mem_ready;
   logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, ExtZero, PCEn, illegal_op;
   logic [1:0] ALUSrcB, PCSrc;
   logic [2:0] ALUOp;
`ifdef CTRL_RETIRE_CNT_EN
   logic [31:0] retired;
`endif

   int   checks = 0;
   int   failures = 0;
   int   cycle_no = 0;
   int   ret_model = 0;
   exp_t q[$];
   logic [5:0] cur_op = '0;
   logic       cur_z = 1'b0;

   always #5 clk = ~clk;

   mips_multicycle_ctrl #(.MEM_WAIT_EN_DEFAULT(1'b1)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .op         (op),
      .zero       (zero),
      .mem_ready  (mem_ready),
      .IorD       (IorD),
      .MemWrite   (MemWrite),
      .IRWrite    (IRWrite),
      .RegDst     (RegDst),
      .MemtoReg   (MemtoReg),
      .RegWrite   (RegWrite),
      .ALUSrcA    (ALUSrcA),
      .ALUSrcB    (ALUSrcB),
      .ExtZero    (ExtZero),
      .ALUOp      (ALUOp),
      .PCSrc      (PCSrc),
      .PCEn       (PCEn),
      .illegal_op (illegal_op)
`ifdef CTRL_RETIRE_CNT_EN
      ,
      .retired    (retired)
`endif
   );

   // Every cycle with a queued expectation is compared against the full control vector.
   always @(negedge clk) begin
      exp_t e;
      exp_t a;
      if (q.size() > 0) begin
         e = q.pop_front();
         a = {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB,
              ExtZero, ALUOp, PCSrc, PCEn, illegal_op};
         checks++;
         if (a !== e) begin
            failures++;
            $display("FAIL ctrl cycle=%0d op=%b act=%h exp=%h", cycle_no, op, a, e);
         end
`ifdef CTRL_RETIRE_CNT_EN
         checks++;
         if (retired !== 32'(ret_model)) begin
            failures++;
            $display("FAIL retired cycle=%0d act=%0d exp=%0d", cycle_no, retired, ret_model);
         end
`endif
      end
      cycle_no++;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         failures++;
         $display("FAIL %s act=%h exp=%h", name, act, exp_v);
      end
   endtask

   // One controller cycle: drive inputs after the edge, queue what the outputs must be.
   task automatic cyc(input exp_t e, input logic rdy);
      @(posedge clk);
      #1;
      op        = cur_op;
      zero      = cur_z;
      mem_ready = rdy;
      q.push_back(e);
      @(negedge clk);
      #1;
   endtask

   function automatic logic legal(input logic [5:0] o);
      case (o)
         6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
         6'b001000, 6'b001010, 6'b001101, 6'b001110, 6'b000010: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // Builds the instruction's cycle-by-cycle trace from its class; fw/mw are wait cycles on memory.
   task automatic run_instr(input logic [5:0] o, input logic z, input int fw, input int mw);
      exp_t e;
      int   mw_hi;
      cur_op = o;
      cur_z  = z;
      for (int i = 0; i < fw; i++) begin
         e = '0; e.srcb = 2'b01; cyc(e, 1'b0);
      end
      e = '0; e.srcb = 2'b01; e.irw = 1'b1; e.pcen = 1'b1; cyc(e, 1'b1);
      e = '0; e.srcb = 2'b11; e.ill = ~legal(o); cyc(e, 1'b1);
      if (!legal(o)) begin
         chk("illegal_pulse", {31'd0, illegal_op}, 32'd1);
         chk("illegal_strobes", {28'd0, MemWrite, IRWrite, RegWrite, PCEn}, 32'd0);
         return;
      end
      case (o)
         6'b100011, 6'b101011: begin
            e = '0; e.srca = 1'b1; e.srcb = 2'b10; cyc(e, 1'b1);
            mw_hi = 0;
            for (int i = 0; i <= mw; i++) begin
               e = '0; e.iord = 1'b1; e.memw = (o == 6'b101011);
               cyc(e, (i == mw));
               mw_hi += int'(MemWrite);
            end
            if (o == 6'b100011) begin
               e = '0; e.mtr = 1'b1; e.regw = 1'b1; cyc(e, 1'b1);
               chk("lw_wb", {30'd0, RegWrite, MemtoReg}, 32'd3);
            end else if (mw == 3) begin
               chk("sw_memwrite_cycles", 32'(mw_hi), 32'd4);
            end
         end
         6'b000000: begin
            e = '0; e.srca = 1'b1; e.aluop = 3'b010; cyc(e, 1'b1);
            e = '0; e.regdst = 1'b1; e.regw = 1'b1; cyc(e, 1'b1);
         end
         6'b000100, 6'b000101: begin
            e = '0; e.srca = 1'b1; e.pcsrc = 2'b01;
            e.aluop = (o == 6'b000100) ? 3'b001 : 3'b100;
            e.pcen  = (o == 6'b000100) ? z : ~z;
            cyc(e, 1'b1);
            if (o == 6'b000100 && z) chk("beq_z1", {28'd0, ALUOp, PCEn}, 32'b0011);
            if (o == 6'b000101 && z) chk("bne_z1", {28'd0, ALUOp, PCEn}, 32'b1000);
         end
         6'b000010: begin
            e = '0; e.pcsrc = 2'b10; e.pcen = 1'b1; cyc(e, 1'b1);
         end
         default: begin
            e = '0; e.srca = 1'b1; e.srcb = 2'b10;
            case (o)
               6'b001010: e.aluop = 3'b011;
               6'b001101: begin e.aluop = 3'b110; e.ext = 1'b1; end
               6'b001110: begin e.aluop = 3'b111; e.ext = 1'b1; end
               default:   e.aluop = 3'b000;
            endcase
            cyc(e, 1'b1);
            if (o == 6'b001101) chk("ori_iexec", {26'd0, ALUOp, ExtZero, ALUSrcB}, 32'b110110);
            e = '0; e.regw = 1'b1; cyc(e, 1'b1);
            if (o == 6'b001101) chk("ori_iwb", {30'd0, RegWrite, RegDst}, 32'b10);
         end
      endcase
      ret_model++;
   endtask

   initial begin
      exp_t e;
      reset_n   = 1'b0;
      op        = '0;
      zero      = 1'b0;
      mem_ready = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      chk("reset_strobes", {28'd0, MemWrite, IRWrite, RegWrite, PCEn}, 32'd0);
      chk("reset_fetch_srcb", {30'd0, ALUSrcB}, 32'b01);
      mem_ready = 1'b0;
      reset_n   = 1'b1;

      run_instr(6'b100011, 1'b0, 0, 0);
      run_instr(6'b100011, 1'b0, 1, 2);
      run_instr(6'b101011, 1'b0, 0, 3);
      run_instr(6'b101011, 1'b0, 2, 0);
      run_instr(6'b000000, 1'b0, 0, 0);
      run_instr(6'b000100, 1'b1, 0, 0);
      run_instr(6'b000100, 1'b0, 0, 0);
      run_instr(6'b000101, 1'b1, 0, 0);
      run_instr(6'b000101, 1'b0, 0, 0);
      run_instr(6'b001000, 1'b0, 0, 0);
      run_instr(6'b001010, 1'b0, 0, 0);
      run_instr(6'b001101, 1'b0, 0, 0);
      run_instr(6'b001110, 1'b0, 0, 0);
      run_instr(6'b000010, 1'b0, 0, 0);
      run_instr(6'b111111, 1'b0, 0, 0);
      run_instr(6'b000011, 1'b1, 0, 0);
      run_instr(6'b000000, 1'b0, 0, 0);

      // Reset in the middle of a store while MemWrite is asserted.
      cur_op = 6'b101011;
      cur_z  = 1'b0;
      e = '0; e.srcb = 2'b01; e.irw = 1'b1; e.pcen = 1'b1; cyc(e, 1'b1);
      e = '0; e.srcb = 2'b11; cyc(e, 1'b1);
      e = '0; e.srca = 1'b1; e.srcb = 2'b10; cyc(e, 1'b1);
      e = '0; e.iord = 1'b1; e.memw = 1'b1; cyc(e, 1'b0);
      chk("memwr_before_reset", {31'd0, MemWrite}, 32'd1);
      #1;
      reset_n = 1'b0;
      ret_model = 0;
      #1;
      chk("reset_async_memwrite", {31'd0, MemWrite}, 32'd0);
      chk("reset_async_strobes", {28'd0, MemWrite, IRWrite, RegWrite, PCEn}, 32'd0);
      @(negedge clk);
      #1;
      mem_ready = 1'b0;
      reset_n   = 1'b1;
      run_instr(6'b001000, 1'b0, 1, 0);
      run_instr(6'b100011, 1'b0, 0, 1);

      @(posedge clk);
      @(negedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout act=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
